// File: rtl/risXv_ifu_pkg.sv
// risXv_ifu_pkg: shared fetch-unit types and widths.
package risXv_ifu_pkg;
    localparam int MXLEN       = 32;
    localparam int FETCH_BYTES = 16;
    localparam int FETCH_SLOTS = FETCH_BYTES / 4;
    localparam int INSTR_W     = 32;

    typedef struct packed {
        logic [MXLEN-1:0]                    pc;
        logic [FETCH_SLOTS-1:0][INSTR_W-1:0] data;
        logic [1:0]                          start_slot;
    } fetch_pkt_t;
endpackage

// File: rtl/ifu_ibuf_slot_sel.sv
// ifu_ibuf_slot_sel: picks the current instruction and its PC out of the head packet.
module ifu_ibuf_slot_sel
    import risXv_ifu_pkg::*;
#(
    parameter int XLEN = MXLEN
) (
    input  fetch_pkt_t         head,
    input  logic [1:0]         slot,
    output logic [XLEN-1:0]    pc,
    output logic [INSTR_W-1:0] instr
);
    logic unused;

    assign pc     = {head.pc[XLEN-1:4], slot, 2'b00};
    assign instr  = head.data[slot];
    assign unused = ^{head.pc[3:0], head.start_slot};
endmodule

// File: rtl/ifu_ibuf.sv
// ifu_ibuf: packet FIFO between fetch and decode, one 32-bit instruction per handshake,
// with a stall to pcGen that keeps room for packets still in flight.
module ifu_ibuf
    import risXv_ifu_pkg::*;
#(
    parameter int XLEN     = MXLEN,
    parameter int DEPTH    = 4,
    parameter int INFLIGHT = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_flush,
    input  logic                 i_fetch_ibuf_valid,
    input  logic [XLEN-1:0]      i_fetch_ibuf_pc,
    input  logic [127:0]         i_fetch_ibuf_data,
    input  logic                 i_dec_ibuf_ready,
    output logic                 o_ibuf_dec_valid,
    output logic [XLEN-1:0]      o_ibuf_dec_pc,
    output logic [INSTR_W-1:0]   o_ibuf_dec_instr,
    output logic                 o_ibuf_pcGen_stall,
    output logic                 o_ibuf_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);
    localparam logic [AW:0] STALL_AT = (AW+1)'(DEPTH - INFLIGHT);

    fetch_pkt_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [AW:0]   count;
    logic [1:0]    slot, in_start, nxt_start;
    logic          ovf, xfer, pop, push, drop;

    assign o_ibuf_dec_valid   = count != '0;
    assign o_ibuf_pcGen_stall = count >= STALL_AT;
    assign o_ibuf_ovf         = ovf;

    always_comb begin
        in_start  = i_fetch_ibuf_pc[3:2];
        rd_nxt    = rd_ptr + AW'(1);
        xfer      = o_ibuf_dec_valid && i_dec_ibuf_ready;
        pop       = xfer && slot == 2'd3;
        push      = i_fetch_ibuf_valid && (count != FULL || pop);
        drop      = i_fetch_ibuf_valid && !push;
        // With one entry left, the next head is the packet arriving this very cycle.
        nxt_start = count == ONE ? (push ? in_start : 2'd0) : mem[rd_nxt].start_slot;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            slot   <= '0;
            ovf    <= 1'b0;
        end else if (i_flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            slot   <= '0;
        end else begin
            ovf    <= ovf | drop;
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_nxt;
            if (count == '0) slot <= push ? in_start : 2'd0;
            else if (xfer) slot <= pop ? nxt_start : slot + 2'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && !i_flush) mem[wr_ptr] <= {i_fetch_ibuf_pc, i_fetch_ibuf_data, in_start};
    end

    ifu_ibuf_slot_sel #(.XLEN(XLEN)) u_slot_sel (
        .head  (mem[rd_ptr]),
        .slot  (slot),
        .pc    (o_ibuf_dec_pc),
        .instr (o_ibuf_dec_instr)
    );
endmodule

// File: tb/tb_ifu_ibuf.sv
// tb_ifu_ibuf: directed stimulus with an instruction-queue reference model checked every cycle.
module tb_ifu_ibuf;
    localparam int DEPTH = 4;
    localparam int INFLIGHT = 2;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_flush = 1'b0;
    logic         i_fetch_ibuf_valid = 1'b0;
    logic [31:0]  i_fetch_ibuf_pc = '0;
    logic [127:0] i_fetch_ibuf_data = '0;
    logic         i_dec_ibuf_ready = 1'b0;
    logic         o_ibuf_dec_valid;
    logic [31:0]  o_ibuf_dec_pc;
    logic [31:0]  o_ibuf_dec_instr;
    logic         o_ibuf_pcGen_stall;
    logic         o_ibuf_ovf;

    int n_chk = 0;
    int n_fail = 0;

    ifu_ibuf #(.XLEN(32), .DEPTH(DEPTH), .INFLIGHT(INFLIGHT)) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_flush            (i_flush),
        .i_fetch_ibuf_valid (i_fetch_ibuf_valid),
        .i_fetch_ibuf_pc    (i_fetch_ibuf_pc),
        .i_fetch_ibuf_data  (i_fetch_ibuf_data),
        .i_dec_ibuf_ready   (i_dec_ibuf_ready),
        .o_ibuf_dec_valid   (o_ibuf_dec_valid),
        .o_ibuf_dec_pc      (o_ibuf_dec_pc),
        .o_ibuf_dec_instr   (o_ibuf_dec_instr),
        .o_ibuf_pcGen_stall (o_ibuf_pcGen_stall),
        .o_ibuf_ovf         (o_ibuf_ovf)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of pending instructions plus the number still owed per packet.
    logic [31:0] q_pc[$];
    logic [31:0] q_in[$];
    int          pk[$];
    bit          m_ovf = 1'b0;

    always @(negedge i_rst_n) begin
        q_pc.delete();
        q_in.delete();
        pk.delete();
        m_ovf = 1'b0;
    end

    always @(posedge i_clk) begin
        int st;
        if (i_rst_n) begin
            if (i_flush) begin
                q_pc.delete();
                q_in.delete();
                pk.delete();
            end else begin
                if (pk.size() != 0 && i_dec_ibuf_ready) begin
                    void'(q_pc.pop_front());
                    void'(q_in.pop_front());
                    pk[0] = pk[0] - 1;
                    if (pk[0] == 0) void'(pk.pop_front());
                end
                if (i_fetch_ibuf_valid) begin
                    if (pk.size() < DEPTH) begin
                        st = int'(i_fetch_ibuf_pc[3:2]);
                        for (int k = st; k < 4; k++) begin
                            q_pc.push_back({i_fetch_ibuf_pc[31:4], 4'(k * 4)});
                            q_in.push_back(i_fetch_ibuf_data[32*k +: 32]);
                        end
                        pk.push_back(4 - st);
                    end else m_ovf = 1'b1;
                end
            end
        end
    end

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            chk("valid", 32'(o_ibuf_dec_valid), 32'(pk.size() != 0));
            if (pk.size() != 0) begin
                chk("pc", o_ibuf_dec_pc, q_pc[0]);
                chk("instr", o_ibuf_dec_instr, q_in[0]);
            end
            chk("stall", 32'(o_ibuf_pcGen_stall), 32'((DEPTH - pk.size()) <= INFLIGHT));
            chk("ovf", 32'(o_ibuf_ovf), 32'(m_ovf));
        end
    end

    function automatic logic [127:0] mk(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [127:0] d);
        i_fetch_ibuf_valid = 1'b1;
        i_fetch_ibuf_pc    = pc;
        i_fetch_ibuf_data  = d;
        step();
        i_fetch_ibuf_valid = 1'b0;
    endtask

    task automatic aligned(input logic [31:0] pc, input logic [31:0] b);
        i_dec_ibuf_ready = 1'b1;
        push(pc, mk(b));
        for (int k = 0; k < 4; k++) begin
            chk("al_valid", 32'(o_ibuf_dec_valid), 32'd1);
            chk("al_pc", o_ibuf_dec_pc, pc + 32'(4 * k));
            chk("al_instr", o_ibuf_dec_instr, b + 32'(k));
            step();
        end
        chk("al_empty", 32'(o_ibuf_dec_valid), 32'd0);
    endtask

    initial begin
        step();
        chk("rst_valid", 32'(o_ibuf_dec_valid), 32'd0);
        chk("rst_stall", 32'(o_ibuf_pcGen_stall), 32'd0);
        chk("rst_ovf", 32'(o_ibuf_ovf), 32'd0);
        step();
        i_rst_n = 1'b1;
        step();

        aligned(32'h8000_0000, 32'hA000_0000);

        push(32'h8000_0008, mk(32'hB000_0000));
        chk("ua_pc0", o_ibuf_dec_pc, 32'h8000_0008);
        chk("ua_in0", o_ibuf_dec_instr, 32'hB000_0002);
        push(32'h8000_0010, mk(32'hC000_0000));
        chk("ua_pc1", o_ibuf_dec_pc, 32'h8000_000C);
        step();
        chk("ua_pc2", o_ibuf_dec_pc, 32'h8000_0010);
        chk("ua_in2", o_ibuf_dec_instr, 32'hC000_0000);
        repeat (4) step();

        i_dec_ibuf_ready = 1'b0;
        push(32'h8000_1000, mk(32'h1000_0000));
        push(32'h8000_1010, mk(32'h1100_0000));
        chk("bp_stall2", 32'(o_ibuf_pcGen_stall), 32'd1);
        push(32'h8000_1020, mk(32'h1200_0000));
        push(32'h8000_1030, mk(32'h1300_0000));
        chk("bp_ovf4", 32'(o_ibuf_ovf), 32'd0);
        chk("bp_hold", o_ibuf_dec_instr, 32'h1000_0000);

        i_dec_ibuf_ready = 1'b1;
        repeat (3) step();
        push(32'h8000_1040, mk(32'h1400_0000));
        i_dec_ibuf_ready = 1'b0;
        chk("fp_ovf", 32'(o_ibuf_ovf), 32'd0);
        chk("fp_stall", 32'(o_ibuf_pcGen_stall), 32'd1);
        chk("fp_head", o_ibuf_dec_pc, 32'h8000_1010);

        push(32'h8000_1050, mk(32'h1500_0000));
        chk("ov_set", 32'(o_ibuf_ovf), 32'd1);
        repeat (2) step();
        chk("ov_sticky", 32'(o_ibuf_ovf), 32'd1);

        i_dec_ibuf_ready = 1'b1;
        repeat (6) step();
        i_dec_ibuf_ready = 1'b0;
        chk("fl_pre", o_ibuf_dec_pc, 32'h8000_1028);
        i_flush = 1'b1;
        push(32'h8000_2000, mk(32'h2000_0000));
        i_flush = 1'b0;
        chk("fl_valid", 32'(o_ibuf_dec_valid), 32'd0);
        chk("fl_stall", 32'(o_ibuf_pcGen_stall), 32'd0);
        chk("fl_ovf", 32'(o_ibuf_ovf), 32'd1);
        i_dec_ibuf_ready = 1'b1;
        push(32'h8000_0100, mk(32'hE000_0000));
        chk("fl_pc", o_ibuf_dec_pc, 32'h8000_0100);
        chk("fl_in", o_ibuf_dec_instr, 32'hE000_0000);
        repeat (4) step();

        i_dec_ibuf_ready = 1'b0;
        push(32'h8000_3000, mk(32'h3000_0000));
        push(32'h8000_3010, mk(32'h3100_0000));
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(o_ibuf_dec_valid), 32'd0);
        chk("ar_stall", 32'(o_ibuf_pcGen_stall), 32'd0);
        chk("ar_ovf", 32'(o_ibuf_ovf), 32'd0);
        step();
        i_rst_n = 1'b1;
        step();
        aligned(32'h8000_0000, 32'hA000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
